// File: rtl/cos_requester.sv
// cos_requester: initiator-side sequencer for the start/done cosine core.
// Accepts one operand pair at a time, starts the core, waits for its done
// pulse (or aborts it after TIMEOUT wait cycles), and queues the 11-bit
// result {err, intpart, fracpart} in a small FIFO for the consumer.
//
// Handshake semantics (both ports): a transfer happens in a cycle where
// valid and ready are both high at the rising edge; ready never depends on
// valid, and a valid side holds its data stable until the transfer.
module cos_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [7:0]  req_y,
  output logic        core_start,
  output logic        core_rst,
  output logic [9:0]  core_x,
  output logic [7:0]  core_y,
  input  logic        core_done,
  input  logic [1:0]  core_intpart,
  input  logic [7:0]  core_fracpart,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [10:0] res_data,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     core_x_q, core_x_d;
  logic [7:0]     core_y_q, core_y_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           abort_q, abort_d;
  logic [7:0]     err_count_q, err_count_d;

  logic [10:0]    mem_q [DEPTH];
  logic [10:0]    mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           push;
  logic           pop;
  logic [10:0]    push_data;

  // Sequencer next-state: accept in IDLE, pulse start, then wait for done or timeout.
  always_comb begin
    state_d     = state_q;
    core_x_d    = core_x_q;
    core_y_d    = core_y_q;
    timer_d     = timer_q;
    abort_d     = 1'b0;
    err_count_d = err_count_q;
    push        = 1'b0;
    push_data   = '0;
    req_ready   = 1'b0;
    core_start  = 1'b0;
    case (state_q)
      IDLE: begin
        // Space is reserved at admission so the later push can never overflow.
        req_ready = !rst && (count_q < CW'(DEPTH));
        if (req_valid && req_ready) begin
          core_x_d = req_x;
          core_y_d = req_y;
          state_d  = START;
        end
      end
      START: begin
        core_start = !rst;
        timer_d    = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          // Done takes priority even on the final timeout cycle.
          push      = 1'b1;
          push_data = {1'b0, core_intpart, core_fracpart};
          state_d   = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          push      = 1'b1;
          push_data = {1'b1, 10'h000};
          abort_d   = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result FIFO bookkeeping: push from WAIT, pop on the result handshake.
  always_comb begin
    mem_d    = mem_q;
    pop      = (count_q != '0) && res_ready;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // State, operand, timer, error and FIFO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      core_x_q    <= '0;
      core_y_q    <= '0;
      timer_q     <= '0;
      abort_q     <= 1'b0;
      err_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      timer_q     <= timer_d;
      abort_q     <= abort_d;
      err_count_q <= err_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Output mapping; the abort pulse lands one cycle after the timeout decision.
  always_comb begin
    core_x    = core_x_q;
    core_y    = core_y_q;
    core_rst  = rst | abort_q;
    res_valid = (count_q != '0);
    res_data  = res_valid ? mem_q[rd_ptr_q] : 11'h000;
    busy      = (state_q != IDLE);
    err_count = err_count_q;
  end

endmodule
